// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit
//   Multi-cycle RV32M divider for DIV, DIVU, REM and REMU. It sits beside the
//   ALU in the execute stage and uses restoring radix-2 division, producing
//   one quotient bit per clock. Pipeline control holds EX while busy=1.
//
//   Ports
//     clk     in   1     clock, rising edge
//     rst     in   1     asynchronous, active-high reset
//     start   in   1     request; sampled only while busy=0
//     op      in   2     00 DIV, 01 DIVU, 10 REM, 11 REMU
//     a       in   XLEN  dividend (rs1)
//     b       in   XLEN  divisor (rs2)
//     busy    out  1     operation in progress; a new start is ignored
//     done    out  1     one-cycle pulse: result valid
//     result  out  XLEN  quotient or remainder; held until the next done
//
//   Handshake: a request is taken on a rising edge where start=1 and busy=0
//   (edge E0). That includes the cycle in which done=1. The result is valid
//   when done=1 and stays stable until the next done pulse.
//
//   Timeline: E0 captures the operands. Edges E1..E_XLEN each retire one
//   quotient bit, and the FIN edge registers the result and raises done.
//   Counting E0 itself, done appears after XLEN+2 edges. Divide-by-zero and
//   signed overflow skip CALC and go straight to FIN, so done appears after
//   2 edges.
// ---------------------------------------------------------------------------
module div_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = (XLEN > 2) ? $clog2(XLEN) : 1;
   localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [CW-1:0]   cnt;
   logic [XLEN-1:0] dvd;     // dividend shifting out, quotient shifting in
   logic [XLEN-1:0] rem;     // partial remainder
   logic [XLEN-1:0] dvs;     // divisor magnitude
   logic            neg_q;
   logic            neg_r;
   logic            op_rem;  // captured op[1]: 1 = return remainder

   // Operand decode, used only at E0.
   logic            is_signed;
   logic [XLEN-1:0] a_abs;
   logic [XLEN-1:0] b_abs;
   logic            b_zero;
   logic            ovf;
   logic            special;

   assign is_signed = ~op[0];
   assign a_abs     = (is_signed && a[XLEN-1]) ? -a : a;
   assign b_abs     = (is_signed && b[XLEN-1]) ? -b : b;
   assign b_zero    = (b == '0);
   assign ovf       = is_signed && (a == MIN_NEG) && (b == '1);
   assign special   = b_zero || ovf;

   // One restoring step. Widening the compare to XLEN+1 bits leaves the
   // borrow in the top bit, so no overflow can occur.
   logic [XLEN:0] rem_sh;
   logic [XLEN:0] diff;
   logic          q_bit;

   assign rem_sh = {rem, dvd[XLEN-1]};
   assign diff   = rem_sh - {1'b0, dvs};
   assign q_bit  = ~diff[XLEN];

   assign busy = (state != IDLE);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = special ? FIN : CALC;
         CALC:    if (cnt == CNT_LAST) state_nxt = FIN;
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         dvd    <= '0;
         rem    <= '0;
         dvs    <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         op_rem <= 1'b0;
         result <= '0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  op_rem <= op[1];
                  cnt    <= '0;
                  if (b_zero) begin
                     // The quotient is all ones and the remainder is the raw
                     // dividend. No sign fixup applies.
                     dvd   <= '1;
                     rem   <= a;
                     neg_q <= 1'b0;
                     neg_r <= 1'b0;
                  end else if (ovf) begin
                     dvd   <= a;
                     rem   <= '0;
                     neg_q <= 1'b0;
                     neg_r <= 1'b0;
                  end else begin
                     dvd   <= a_abs;
                     dvs   <= b_abs;
                     rem   <= '0;
                     neg_q <= is_signed && (a[XLEN-1] ^ b[XLEN-1]);
                     neg_r <= is_signed && a[XLEN-1];
                  end
               end
            end
            CALC: begin
               cnt <= cnt + 1'b1;
               dvd <= {dvd[XLEN-2:0], q_bit};
               rem <= q_bit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
            end
            FIN: begin
               if (op_rem) result <= neg_r ? -rem : rem;
               else        result <= neg_q ? -dvd : dvd;
               done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// ---------------------------------------------------------------------------
// tb_div_unit
//   Directed and random checks of div_unit at XLEN=32. Expected results and
//   latencies are pushed to queues when a request is accepted. A monitor pops
//   and compares them on each done pulse.
// ---------------------------------------------------------------------------
module tb_div_unit;

   localparam int XLEN = 32;
   localparam int LAT_FULL = XLEN + 2;
   localparam int LAT_SPEC = 2;

   logic            clk;
   logic            rst;
   logic            start;
   logic [1:0]      op;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   div_unit #(.XLEN(XLEN)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int edge_cnt = 0;
   always @(posedge clk) edge_cnt++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- scoreboard ----------------
   logic [XLEN-1:0] exp_q[$];
   int              lat_q[$];
   int              e0_q[$];
   int              checks   = 0;
   int              failures = 0;

   task automatic chk(input string tag, input logic [XLEN-1:0] obs,
                      input logic [XLEN-1:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   logic prev_done = 1'b0;

   always @(negedge clk) begin
      if (!rst) begin
         if (busy || done) chk("busy_done_excl", {31'b0, busy & done}, '0);
         if (done) begin
            chk("done_one_cycle", {31'b0, prev_done}, '0);
            if (exp_q.size() == 0) begin
               chk("unexpected_done", {31'b0, done}, '0);
            end else begin
               logic [XLEN-1:0] e;
               int              l;
               int              s;
               e = exp_q.pop_front();
               l = lat_q.pop_front();
               s = e0_q.pop_front();
               chk("result", result, e);
               chk("latency", XLEN'(edge_cnt - s + 1), XLEN'(l));
            end
         end
         prev_done = done;
      end else begin
         prev_done = 1'b0;
      end
   end

   // ---------------- reference model ----------------
   function automatic logic [XLEN-1:0] model(input logic [1:0] o,
                                             input logic [XLEN-1:0] x,
                                             input logic [XLEN-1:0] y);
      logic signed [XLEN-1:0] sx;
      logic signed [XLEN-1:0] sy;
      logic                   ov;
      sx = x;
      sy = y;
      ov = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
      case (o)
         2'b00:   model = (y == 0) ? 32'hFFFF_FFFF : ov ? x : XLEN'(sx / sy);
         2'b01:   model = (y == 0) ? 32'hFFFF_FFFF : x / y;
         2'b10:   model = (y == 0) ? x : ov ? 32'h0 : XLEN'(sx % sy);
         default: model = (y == 0) ? x : x % y;
      endcase
   endfunction

   function automatic int model_lat(input logic [1:0] o,
                                    input logic [XLEN-1:0] x,
                                    input logic [XLEN-1:0] y);
      if (y == 0) return LAT_SPEC;
      if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return LAT_SPEC;
      return LAT_FULL;
   endfunction

   // ---------------- driver tasks ----------------
   // Enter at a negedge. Waits for busy=0, then drives one request through
   // its E0 edge and records the expectations.
   task automatic issue(input logic [1:0] o, input logic [XLEN-1:0] x,
                        input logic [XLEN-1:0] y, input logic [XLEN-1:0] e,
                        input int lat);
      for (int i = 0; i < 200 && busy; i++) @(negedge clk);
      if (busy) chk("issue_wait_idle", {31'b0, busy}, '0);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      @(posedge clk);
      #1;
      exp_q.push_back(e);
      lat_q.push_back(lat);
      e0_q.push_back(edge_cnt);
      start = 1'b0;
      op    = $urandom_range(0, 3);
      a     = $urandom;
      b     = $urandom;
      chk("accepted_busy", {31'b0, busy}, 32'h1);
   endtask

   task automatic wait_all(input int max_cycles);
      for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) @(negedge clk);
      @(negedge clk);
      chk("drain_queue", XLEN'(exp_q.size()), '0);
   endtask

   task automatic wait_done_pulse(input int max_cycles);
      for (int i = 0; i < max_cycles; i++) begin
         @(negedge clk);
         if (done) break;
      end
      chk("done_seen", {31'b0, done}, 32'h1);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [1:0]      ro;
      logic [XLEN-1:0] rx;
      logic [XLEN-1:0] ry;

      rst   = 1'b1;
      start = 1'b0;
      op    = 2'b00;
      a     = '0;
      b     = '0;
      repeat (2) @(negedge clk);
      chk("reset_busy",   {31'b0, busy}, '0);
      chk("reset_done",   {31'b0, done}, '0);
      chk("reset_result", result, '0);
      rst = 1'b0;
      @(negedge clk);

      // T1: basic signed divide, full latency, result held afterwards
      issue(2'b00, 32'd100, 32'd7, 32'd14, LAT_FULL);
      wait_all(100);
      repeat (3) @(negedge clk);
      chk("result_hold", result, 32'd14);

      // T2: signed truncation toward zero
      issue(2'b10, -32'sd7, 32'd2, 32'hFFFF_FFFF, LAT_FULL);
      issue(2'b00, -32'sd7, 32'd2, 32'hFFFF_FFFD, LAT_FULL);
      // T3: unsigned full-range dividend
      issue(2'b01, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, LAT_FULL);
      issue(2'b11, 32'hFFFF_FFFF, 32'd2, 32'd1, LAT_FULL);
      wait_all(300);

      // T4: special cases, short latency
      issue(2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, LAT_SPEC);
      issue(2'b11, 32'd5, 32'd0, 32'd5, LAT_SPEC);
      issue(2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, LAT_SPEC);
      issue(2'b10, -32'sd5, 32'd0, 32'hFFFF_FFFB, LAT_SPEC);
      issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SPEC);
      issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, LAT_SPEC);
      wait_all(100);

      // Zero dividend and most-negative dividend on the normal path
      issue(2'b00, 32'd0, 32'd5, 32'd0, LAT_FULL);
      issue(2'b10, 32'd0, 32'd5, 32'd0, LAT_FULL);
      issue(2'b00, 32'h8000_0000, 32'd2, 32'hC000_0000, LAT_FULL);
      issue(2'b11, 32'd6, 32'd7, 32'd6, LAT_FULL);
      wait_all(300);

      // Random operands against the behavioural model
      for (int i = 0; i < 10; i++) begin
         ro = 2'($urandom_range(0, 3));
         rx = $urandom;
         ry = $urandom >> $urandom_range(0, 31);
         if (i == 3) ry = 32'h0;
         if (i == 6) ry = 32'hFFFF_FFFF;
         issue(ro, rx, ry, model(ro, rx, ry), model_lat(ro, rx, ry));
      end
      wait_all(600);

      // T5: start while busy is ignored; a start during done is accepted
      issue(2'b00, 32'd1000, 32'd10, 32'd100, LAT_FULL);
      repeat (5) @(negedge clk);
      start = 1'b1;
      op    = 2'b01;
      a     = 32'd77;
      b     = 32'd7;
      @(negedge clk);
      start = 1'b0;
      wait_done_pulse(100);
      issue(2'b01, 32'd50, 32'd5, 32'd10, LAT_FULL);
      wait_all(100);
      repeat (40) @(negedge clk);

      // T6: reset mid-CALC aborts with no later done
      issue(2'b00, 32'd1000, 32'd3, 32'd333, LAT_FULL);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_busy",   {31'b0, busy}, '0);
      chk("abort_done",   {31'b0, done}, '0);
      chk("abort_result", result, '0);
      exp_q.delete();
      lat_q.delete();
      e0_q.delete();
      @(negedge clk);
      rst = 1'b0;
      repeat (60) @(negedge clk);
      issue(2'b01, 32'd9, 32'd3, 32'd3, LAT_FULL);
      wait_all(100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
